// File: rtl/bdp_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : bdp_accumulator_if
// Brief    : Beat-in / result-out handshake bundle for the bit-plane
//            dot-product accumulator.
// Revision : 1.0 - initial release
// ============================================================================

interface bdp_accumulator_if #(
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 18
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PSUM_W-1:0] in_psum;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [3:0]               out_count;
  logic                     out_sat;
  logic                     out_err;

  // Upstream producer and downstream consumer side.
  modport master (
    output in_valid, in_psum, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_sat, out_err
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_psum, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_sat, out_err
  );
endinterface

`default_nettype wire

// File: rtl/bdp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : bdp_accumulator
// Brief    : Sums signed bit-plane partial sums into a saturating dot-product
//            result; one result per vector, held until the consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================

module bdp_accumulator #(
  parameter int PSUM_W     = 16,
  parameter int ACC_W      = 18,
  parameter int MAX_PLANES = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  bdp_accumulator_if.slave bus
);

  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [3:0]              c_max_cnt = 4'(MAX_PLANES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic signed [ACC_W-1:0] r_acc;
  logic [3:0]              r_count;
  logic                    r_sat;

  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;
  logic [3:0]              r_out_count;
  logic                    r_out_sat;
  logic                    r_out_err;

  logic                    w_in_ready;
  logic                    w_beat;
  logic                    w_close;
  logic signed [ACC_W-1:0] w_psum_ext;
  logic signed [ACC_W-1:0] w_acc_base;
  logic [ACC_W:0]          w_sum;
  logic                    w_ovf;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [3:0]              w_count_next;
  logic                    w_sat_next;

  generate
    if (ACC_W > PSUM_W) begin : g_ext
      assign w_psum_ext = {{(ACC_W-PSUM_W){bus.in_psum[PSUM_W-1]}}, bus.in_psum};
    end else begin : g_noext
      assign w_psum_ext = bus.in_psum;
    end
  endgenerate

  // A first beat starts from zero, so it can never saturate.
  assign w_acc_base   = (r_state == ST_ACCUM) ? r_acc : '0;
  assign w_sum        = {w_acc_base[ACC_W-1], w_acc_base} + {w_psum_ext[ACC_W-1], w_psum_ext};
  assign w_ovf        = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_next   = !w_ovf        ? w_sum[ACC_W-1:0] :
                        w_sum[ACC_W]  ? c_acc_min        : c_acc_max;
  assign w_count_next = (r_state == ST_ACCUM) ? (r_count + 4'd1) : 4'd1;
  assign w_sat_next   = ((r_state == ST_ACCUM) && r_sat) || w_ovf;
  assign w_close      = bus.in_last || (w_count_next == c_max_cnt);
  assign w_beat       = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_err   = r_out_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // No bypass: the result slot must drain before the next vector may start.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = w_close ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_count     <= 4'd0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= 4'd0;
      r_out_sat   <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_beat) begin
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
      r_sat   <= w_sat_next;
      if (w_close) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_next;
        r_out_count <= w_count_next;
        r_out_sat   <= w_sat_next;
        r_out_err   <= !bus.in_last;
      end
    end else if ((r_state == ST_HOLD) && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bdp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bdp_accumulator
// Brief    : Table-driven and scoreboarded bench for bdp_accumulator.
// Revision : 1.0 - initial release
// ============================================================================

module tb_bdp_accumulator;

  localparam int PSUM_W     = 16;
  localparam int ACC_W      = 18;
  localparam int MAX_PLANES = 8;
  localparam int ACC_MAX    = 131071;
  localparam int ACC_MIN    = -131072;

  typedef struct {
    int data;
    int count;
    bit sat;
    bit err;
  } res_t;

  typedef struct {
    int   n;
    bit   lastf;
    int   p[8];
    res_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  bdp_accumulator_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();

  bdp_accumulator #(
    .PSUM_W    (PSUM_W),
    .ACC_W     (ACC_W),
    .MAX_PLANES(MAX_PLANES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  res_t exp_q[$];
  res_t mon_e;
  vec_t tbl[9];
  vec_t rv;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data",  bus.out_data,  mon_e.data);
        check("out_count", bus.out_count, mon_e.count);
        check("out_sat",   bus.out_sat,   mon_e.sat);
        check("out_err",   bus.out_err,   mon_e.err);
      end
    end
  end

  function automatic res_t model(input int n, input int p[8], input bit lastf);
    res_t   r;
    longint acc;
    acc   = 0;
    r.sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + p[i];
      if (acc > ACC_MAX) begin acc = ACC_MAX; r.sat = 1'b1; end
      if (acc < ACC_MIN) begin acc = ACC_MIN; r.sat = 1'b1; end
    end
    r.data  = int'(acc);
    r.count = n;
    r.err   = !lastf;
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send_beat(input int p, input bit last);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_psum  = PSUM_W'(p);
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    exp_q.push_back(v.exp);
    for (int i = 0; i < v.n; i++) begin
      send_beat(v.p[i], v.lastf && (i == v.n - 1));
    end
    @(negedge clk);
    check("latency_out_valid", bus.out_valid, 1);
    if (bus.out_ready) begin
      @(negedge clk);
      check("out_valid_drop", bus.out_valid, 0);
      check("in_ready_after_handshake", bus.in_ready, 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3, 1'b1, '{100, 200, -50, 0, 0, 0, 0, 0}, '{250, 3, 1'b0, 1'b0}};
    tbl[1] = '{1, 1'b1, '{-32768, 0, 0, 0, 0, 0, 0, 0}, '{-32768, 1, 1'b0, 1'b0}};
    tbl[2] = '{8, 1'b1, '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767},
               '{131071, 8, 1'b1, 1'b0}};
    tbl[3] = '{8, 1'b0, '{1, 1, 1, 1, 1, 1, 1, 1}, '{8, 8, 1'b0, 1'b1}};
    tbl[4] = '{1, 1'b1, '{5, 0, 0, 0, 0, 0, 0, 0}, '{5, 1, 1'b0, 1'b0}};
    tbl[5] = '{8, 1'b0, '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768},
               '{-131072, 8, 1'b1, 1'b1}};
    tbl[6] = '{6, 1'b1, '{32767, 32767, 32767, 32767, 32767, -32768, 0, 0},
               '{98303, 6, 1'b1, 1'b0}};
    tbl[7] = '{2, 1'b1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 2, 1'b0, 1'b0}};
    tbl[8] = '{7, 1'b1, '{-1, -1, -1, -1, -1, -1, -1, 0}, '{-7, 7, 1'b0, 1'b0}};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_psum   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data",  bus.out_data,  0);
    check("reset_out_count", bus.out_count, 0);
    check("reset_out_sat",   bus.out_sat,   0);
    check("reset_out_err",   bus.out_err,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    foreach (tbl[i]) send_vec(tbl[i]);

    // Result held under back-pressure while upstream keeps offering a beat.
    bus.out_ready = 1'b0;
    exp_q.push_back('{11, 2, 1'b0, 1'b0});
    send_beat(5, 1'b0);
    send_beat(6, 1'b1);
    exp_q.push_back('{99, 1, 1'b0, 1'b0});
    bus.in_valid = 1'b1;
    bus.in_psum  = PSUM_W'(99);
    bus.in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data",  bus.out_data,  11);
      check("stall_out_count", bus.out_count, 2);
      check("stall_in_ready",  bus.in_ready,  0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_release_out_valid", bus.out_valid, 0);
    check("stall_release_in_ready",  bus.in_ready,  1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("held_beat_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;

    // Reset while a result is pending discards it.
    bus.out_ready = 1'b0;
    send_beat(1234, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_reset_out_valid", bus.out_valid, 0);
    check("hold_reset_out_data",  bus.out_data,  0);
    check("hold_reset_in_ready",  bus.in_ready,  1);
    @(posedge clk);
    #1;

    // Reset mid-vector: only the vector after reset may produce a result.
    send_beat(10, 1'b0);
    send_beat(20, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rv = '{1, 1'b1, '{7, 0, 0, 0, 0, 0, 0, 0}, '{7, 1, 1'b0, 1'b0}};
    send_vec(rv);

    // Random vectors against the reference model, biased toward saturation.
    for (int k = 0; k < 20; k++) begin
      rv.n     = int'($urandom_range(1, MAX_PLANES));
      rv.lastf = (rv.n < MAX_PLANES) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0)
          rv.p[i] = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
        else
          rv.p[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      rv.exp = model(rv.n, rv.p, rv.lastf);
      send_vec(rv);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bdp_accumulator.md
BDP_ACCUMULATOR -- requirements
Module: bdp_accumulator

Interface
REQ-001 Parameter PSUM_W, default 16: width of the signed bit-plane partial sum from the bit-serial dot-product stage.
REQ-002 Parameter ACC_W, default 18: width of the signed accumulator and result; ACC_W >= PSUM_W.
REQ-003 Parameter MAX_PLANES, default 8: maximum bit-plane beats per vector.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  in_psum/in_last are valid this cycle.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_psum  input  PSUM_W  signed, already-shifted bit-plane partial sum.
REQ-009 in_last  input  1  beat is the final bit-plane of the current vector.
REQ-010 out_valid  output  1  out_data/out_count/out_sat/out_err are valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_data  output  ACC_W  signed accumulated dot-product result.
REQ-013 out_count  output  4  number of beats accumulated into out_data (1..MAX_PLANES).
REQ-014 out_sat  output  1  saturation occurred at any beat of this vector.
REQ-015 out_err  output  1  vector was force-closed at MAX_PLANES without in_last.

Function
REQ-016 Beat accepted iff in_valid && in_ready at a rising edge; nothing else changes accumulator state.
REQ-017 States: IDLE (no beats of current vector), ACCUM (>=1 beat, no last), HOLD (result presented, awaiting out_ready).
REQ-018 in_ready = 1 in IDLE and ACCUM; 0 in HOLD, including the cycle out_ready is high (no bypass).
REQ-019 Beat in IDLE: acc <= sign-extended in_psum, count <= 1, sat <= 0; go to ACCUM, or to HOLD if closing.
REQ-020 Beat in ACCUM: acc <= sat(acc + sign-extended in_psum), count <= count+1; sat flag sticky-ORs this beat's saturation.
REQ-021 Addition at ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; clamping sets sat.
REQ-022 Beat closes the vector if in_last=1 or it is beat number MAX_PLANES; closing beat with in_last=0 sets err.
REQ-023 On closing beat at edge t: out_data/out_count/out_sat/out_err load final values and out_valid=1 from edge t (visible cycle t+1); state HOLD.
REQ-024 Outputs stay stable while out_valid && !out_ready.
REQ-025 HOLD with out_ready=1 at edge: out_valid <= 0, state IDLE; in_ready high next cycle.
REQ-026 out_data/out_count/out_sat/out_err keep last values after out_valid drops; meaningful only with out_valid.
REQ-027 in_valid while in_ready=0 is ignored (upstream holds data).
REQ-028 Latency: closing beat to out_valid 1 cycle; minimum vector period = beats + 1 cycle.

Reset
REQ-029 rst=1 at an edge: state IDLE, acc=0, internal count=0, out_valid=0, out_data=0, out_count=0, out_sat=0, out_err=0; in_ready=1 after reset released.
REQ-030 rst mid-vector or in HOLD discards the partial/pending result; no output for it is ever produced.
REQ-031 rst has priority over any beat or out_ready in the same cycle.

Verification
REQ-032 Beats 100, 200, -50(last), out_ready=1 -> out_valid one cycle after third beat, out_data=250, out_count=3, out_sat=0, out_err=0.
REQ-033 Single beat -32768 with in_last=1 -> out_data=-32768, out_count=1, then IDLE with in_ready=1 after handshake.
REQ-034 8 beats of 32767, last on 8th -> out_data=131071, out_sat=1, out_err=0, out_count=8.
REQ-035 8 beats of 1, in_last=0 throughout -> forced close, out_data=8, out_count=8, out_err=1; 9th beat starts new vector.
REQ-036 Result pending, out_ready=0 for 5 cycles with in_valid=1 -> out_valid and out_data stable, in_ready=0, no beat consumed; out_ready=1 -> out_valid drops next cycle.
REQ-037 Beats 10, 20, then rst 1 cycle, then 7(last) -> no output for the aborted vector; out_data=7, out_count=1.
